spi_slave_sync: RTL and testbench

// - SPI slave (responder) clocked entirely in the system domain; oversamples SCLK/CS_n/MOSI, no logic on SCLK.
// - Counterpart to SPI_MASTER for on-chip targets that cannot run from SCLK; full-duplex, MSB first, 8-bit frames.
// - Multi-byte transfers under one CS_n low; byte-level valid/ready user interface.

---
 rtl/spi_sync_pkg.sv | 19 +
 rtl/spi_edge_sync.sv | 33 +++
 rtl/spi_slave_sync.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_sync.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sync_pkg.sv
// Shared types and helpers for the system-clocked SPI slave (spi_slave_sync).
package spi_sync_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    // Splits an SPI mode number 0..3 into {cpol, cpha}.
    function automatic logic [1:0] mode_bits(input int mode);
        logic [1:0] bits;
        bits = mode[1:0];
        return bits;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle rise/fall pulses
// derived from the synchronized level and a one-cycle-delayed copy of it.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Reset to the line's idle level so that leaving reset produces no spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave clocked entirely from the system clock: oversamples SCLK/CS_n/MOSI, full-duplex MSB-first bytes.
// Defining SPI_SLAVE_STATUS_EN adds sticky RX-overrun / TX-underrun flags with ack and clear inputs.
module spi_slave_sync
    import spi_sync_pkg::*;
#(
    parameter int                SPI_MODE    = 0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic              i_slave_clk,
    input  logic              i_slave_rst,
    input  logic              i_SLAVE_TX_VALID,
    input  logic [BYTE_W-1:0] i_SLAVE_TX_BYTE,
    output logic              o_SLAVE_TX_READY,
    output logic              o_SLAVE_RX_VALID,
    output logic [BYTE_W-1:0] o_SLAVE_RX_BYTE,
    output logic              o_SLAVE_BUSY,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic              i_SLAVE_RX_ACK,
    input  logic              i_SLAVE_STATUS_CLR,
    output logic              o_SLAVE_RX_OVERRUN,
    output logic              o_SLAVE_TX_UNDERRUN,
`endif
    input  logic              i_SLAVE_SPI_SCLK,
    input  logic              i_SLAVE_SPI_CS_n,
    input  logic              i_SLAVE_SPI_MOSI,
    output logic              o_SLAVE_SPI_MISO,
    output logic              o_SLAVE_SPI_MISO_OE
);

    localparam logic [1:0] MODE_BITS = mode_bits(SPI_MODE);
    localparam logic       CPOL      = MODE_BITS[1];
    localparam logic       CPHA      = MODE_BITS[0];
    localparam int         CNT_W     = $clog2(BYTE_W);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    state_t              state, next_state;
    logic [BYTE_W-1:0]   tx_shift, rx_shift, rx_byte, hold_byte;
    logic [CNT_W-1:0]    bit_cnt;
    logic                hold_full, tx_ready, rx_valid, miso_oe;
    logic                lead_edge, trail_edge, sample_edge, shift_edge, last_bit;
    logic                load_now, rx_done, accept, take, hold_full_next;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .clk(i_slave_clk), .rst(i_slave_rst), .async_in(i_SLAVE_SPI_SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(i_slave_clk), .rst(i_slave_rst), .async_in(i_SLAVE_SPI_CS_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(i_slave_clk), .rst(i_slave_rst), .async_in(i_SLAVE_SPI_MOSI),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_level, cs_rise, mosi_rise, mosi_fall};

    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign last_bit    = (bit_cnt == CNT_W'(BYTE_W - 1));

    assign load_now = (state == LOAD) && !cs_level;
    assign rx_done  = (state == SHIFT) && !cs_level && sample_edge && last_bit;
    assign accept   = i_SLAVE_TX_VALID && tx_ready;
    assign take     = load_now && hold_full;
    assign hold_full_next = take ? 1'b0 : (accept ? 1'b1 : hold_full);

    always_ff @(posedge i_slave_clk) begin
        if (i_slave_rst) state <= IDLE;
        else             state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (cs_level) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) next_state = LOAD;
                LOAD:    next_state = SHIFT;
                SHIFT:   if (sample_edge && last_bit) next_state = LOAD;
                default: next_state = IDLE;
            endcase
        end
    end

    // A byte accepted in the same cycle as LOAD stays in holding; LOAD only sees what was already there.
    always_ff @(posedge i_slave_clk) begin
        if (i_slave_rst) begin
            hold_full <= 1'b0;
            hold_byte <= '0;
            tx_ready  <= 1'b0;
        end else begin
            hold_full <= hold_full_next;
            tx_ready  <= !hold_full_next;
            if (accept) hold_byte <= i_SLAVE_TX_BYTE;
        end
    end

    // The first shift edge of each byte only presents the MSB already loaded, hence the bit_cnt guard.
    always_ff @(posedge i_slave_clk) begin
        if (i_slave_rst) begin
            tx_shift <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            bit_cnt  <= '0;
            rx_valid <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_level) begin
                tx_shift <= '0;
                rx_shift <= '0;
                bit_cnt  <= '0;
                miso_oe  <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        tx_shift <= hold_full ? hold_byte : DEFAULT_TX;
                        bit_cnt  <= '0;
                        miso_oe  <= 1'b1;
                    end
                    SHIFT: begin
                        if (shift_edge && bit_cnt != '0) tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[BYTE_W-2:0], mosi_level};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                        if (rx_done) begin
                            rx_byte  <= {rx_shift[BYTE_W-2:0], mosi_level};
                            rx_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic rx_pending, rx_overrun, tx_underrun;

    // Sticky flags: a set condition beats a simultaneous clear.
    always_ff @(posedge i_slave_clk) begin
        if (i_slave_rst) begin
            rx_pending  <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_pending <= rx_done | (rx_pending & ~i_SLAVE_RX_ACK);
            if (rx_done && rx_pending && !i_SLAVE_RX_ACK) rx_overrun <= 1'b1;
            else if (i_SLAVE_STATUS_CLR)                  rx_overrun <= 1'b0;
            if (load_now && !hold_full)    tx_underrun <= 1'b1;
            else if (i_SLAVE_STATUS_CLR)   tx_underrun <= 1'b0;
        end
    end

    assign o_SLAVE_RX_OVERRUN  = rx_overrun;
    assign o_SLAVE_TX_UNDERRUN = tx_underrun;
`endif

    assign o_SLAVE_TX_READY    = tx_ready;
    assign o_SLAVE_RX_VALID    = rx_valid;
    assign o_SLAVE_RX_BYTE     = rx_byte;
    assign o_SLAVE_BUSY        = ~cs_level;
    assign o_SLAVE_SPI_MISO    = miso_oe & tx_shift[BYTE_W-1];
    assign o_SLAVE_SPI_MISO_OE = miso_oe;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: one slave per SPI mode, each driven by a behavioural SPI master.
// Status-flag checks are compiled in when SPI_SLAVE_STATUS_EN is defined.
module tb_spi_slave_sync;

    localparam int         HP     = 4;
    localparam logic [7:0] DEF_TX = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tx_valid, tx_ready, rx_valid, busy, miso, miso_oe;
    logic [3:0] sclk, cs_n, mosi;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte [4];
`ifdef SPI_SLAVE_STATUS_EN
    logic       rx_ack, status_clr;
    logic [3:0] rx_overrun, tx_underrun;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] rx_seen [$];
    logic [7:0] tx_model [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(.SPI_MODE(g), .SYNC_STAGES(2), .DEFAULT_TX(DEF_TX)) dut (
            .i_slave_clk(clk),
            .i_slave_rst(rst),
            .i_SLAVE_TX_VALID(tx_valid[g]),
            .i_SLAVE_TX_BYTE(tx_byte),
            .o_SLAVE_TX_READY(tx_ready[g]),
            .o_SLAVE_RX_VALID(rx_valid[g]),
            .o_SLAVE_RX_BYTE(rx_byte[g]),
            .o_SLAVE_BUSY(busy[g]),
`ifdef SPI_SLAVE_STATUS_EN
            .i_SLAVE_RX_ACK(rx_ack),
            .i_SLAVE_STATUS_CLR(status_clr),
            .o_SLAVE_RX_OVERRUN(rx_overrun[g]),
            .o_SLAVE_TX_UNDERRUN(tx_underrun[g]),
`endif
            .i_SLAVE_SPI_SCLK(sclk[g]),
            .i_SLAVE_SPI_CS_n(cs_n[g]),
            .i_SLAVE_SPI_MOSI(mosi[g]),
            .o_SLAVE_SPI_MISO(miso[g]),
            .o_SLAVE_SPI_MISO_OE(miso_oe[g])
        );
    end

    // Only one slave is active at a time, so a single log of received bytes is enough.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (rx_valid[k] === 1'b1) rx_seen.push_back(rx_byte[k]);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_tx(input int m, input logic [7:0] b);
        int waited = 0;
        while (tx_ready[m] !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (tx_ready[m] !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL push_ready mode %0d: ready=%b, required 1 within 400 clk", m, tx_ready[m]);
        end else begin
            tx_byte     = b;
            tx_valid[m] = 1'b1;
            tx_model.push_back(b);
            @(negedge clk);
            tx_valid[m] = 1'b0;
        end
    endtask

    task automatic spi_xfer(input int m, input int nbits, input logic [7:0] mtx [3], input bit keep_low,
                            output logic [7:0] mrx [3], output bit oe_ok);
        logic [1:0] mb;
        mb    = 2'(m);
        oe_ok = 1'b1;
        for (int k = 0; k < 3; k++) mrx[k] = 8'h00;
        cs_n[m] = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            int byte_idx, bit_idx;
            byte_idx = b / 8;
            bit_idx  = 7 - (b % 8);
            if (!mb[0]) begin
                mosi[m] = mtx[byte_idx][bit_idx];
                repeat (HP) @(negedge clk);
                sclk[m] = ~mb[1];
                mrx[byte_idx][bit_idx] = miso[m];
                if (miso_oe[m] !== 1'b1) oe_ok = 1'b0;
                repeat (HP) @(negedge clk);
                sclk[m] = mb[1];
            end else begin
                sclk[m] = ~mb[1];
                mosi[m] = mtx[byte_idx][bit_idx];
                repeat (HP) @(negedge clk);
                sclk[m] = mb[1];
                mrx[byte_idx][bit_idx] = miso[m];
                if (miso_oe[m] !== 1'b1) oe_ok = 1'b0;
                repeat (HP) @(negedge clk);
            end
        end
        if (!keep_low) begin
            repeat (HP) @(negedge clk);
            cs_n[m] = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    // Offers the first `offer` slave bytes: one before CS_n falls, the rest whenever READY returns.
    task automatic run_frame(input int m, input int n, input logic [7:0] mtx [3], input logic [7:0] sb [3],
                             input int offer, output logic [7:0] mrx [3], output bit oe_ok);
        rx_seen.delete();
        if (offer > 0) push_tx(m, sb[0]);
        fork
            spi_xfer(m, n * 8, mtx, 1'b0, mrx, oe_ok);
            begin
                for (int k = 1; k < offer; k++) push_tx(m, sb[k]);
            end
        join
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            tests_run++;
            if ({tx_ready[m], rx_valid[m], busy[m], miso[m], miso_oe[m]} !== 5'b0 || rx_byte[m] !== 8'h00) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs mode %0d: rdy/vld/busy/miso/oe=%b%b%b%b%b byte=%02h, required all 0",
                         m, tx_ready[m], rx_valid[m], busy[m], miso[m], miso_oe[m], rx_byte[m]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx_ready !== 4'hF) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: tx_ready=%b, required 1111", tx_ready);
        end
    endtask

    task automatic test_single;
        logic [7:0] mtx [3];
        logic [7:0] sb [3];
        logic [7:0] mrx [3];
        logic [7:0] expected;
        bit oe_ok;
        mtx = '{8'hAA, 8'h00, 8'h00};
        sb  = '{8'hDD, 8'h00, 8'h00};
        run_frame(0, 1, mtx, sb, 1, mrx, oe_ok);
        expected = (tx_model.size() != 0) ? tx_model.pop_front() : DEF_TX;
        tests_run++;
        if (mrx[0] !== expected) begin
            tests_failed++;
            $display("[TB] FAIL single_master_rx: got %02h, expected %02h", mrx[0], expected);
        end
        tests_run++;
        if (rx_seen.size() != 1 || rx_seen[0] !== mtx[0]) begin
            tests_failed++;
            $display("[TB] FAIL single_slave_rx: %0d pulses, first %02h, expected 1 pulse of %02h",
                     rx_seen.size(), (rx_seen.size() != 0) ? rx_seen[0] : 8'hxx, mtx[0]);
        end
        tests_run++;
        if (!oe_ok) begin
            tests_failed++;
            $display("[TB] FAIL single_miso_oe: oe was low at a master sample edge, required high");
        end
    endtask

    task automatic test_burst;
        logic [7:0] mtx [3];
        logic [7:0] sb [3];
        logic [7:0] mrx [3];
        logic [7:0] expected, got;
        bit oe_ok;
        for (int k = 0; k < 3; k++) mtx[k] = 8'($urandom);
        sb = '{8'hDD, 8'hEE, 8'h02};
        run_frame(0, 3, mtx, sb, 3, mrx, oe_ok);
        tests_run++;
        if (rx_seen.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL burst_rx_pulses: got %0d, expected 3", rx_seen.size());
        end
        for (int k = 0; k < 3; k++) begin
            expected = (tx_model.size() != 0) ? tx_model.pop_front() : DEF_TX;
            got      = (k < rx_seen.size()) ? rx_seen[k] : 8'hxx;
            tests_run++;
            if (mrx[k] !== expected || got !== mtx[k]) begin
                tests_failed++;
                $display("[TB] FAIL burst_byte[%0d]: master got %02h exp %02h, slave got %02h exp %02h",
                         k, mrx[k], expected, got, mtx[k]);
            end
        end
    endtask

    task automatic test_underrun;
        logic [7:0] mtx [3];
        logic [7:0] sb [3];
        logic [7:0] mrx [3];
        logic [7:0] expected;
        bit oe_ok;
        mtx = '{8'($urandom), 8'h00, 8'h00};
        sb  = '{8'h00, 8'h00, 8'h00};
        run_frame(0, 1, mtx, sb, 0, mrx, oe_ok);
        expected = (tx_model.size() != 0) ? tx_model.pop_front() : DEF_TX;
        tests_run++;
        if (mrx[0] !== expected || rx_seen.size() != 1 || rx_seen[0] !== mtx[0]) begin
            tests_failed++;
            $display("[TB] FAIL underrun_exchange: master got %02h exp %02h, slave pulses %0d exp 1 of %02h",
                     mrx[0], expected, rx_seen.size(), mtx[0]);
        end
`ifdef SPI_SLAVE_STATUS_EN
        tests_run++;
        if (tx_underrun[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL underrun_flag_set: got %b, expected 1", tx_underrun[0]);
        end
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx_underrun[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL underrun_flag_clear: got %b, expected 0", tx_underrun[0]);
        end
`endif
    endtask

    task automatic test_abort;
        logic [7:0] mtx [3];
        logic [7:0] sb [3];
        logic [7:0] mrx [3];
        logic [7:0] expected;
        bit oe_ok;
        mtx = '{8'($urandom), 8'h00, 8'h00};
        rx_seen.delete();
        spi_xfer(0, 4, mtx, 1'b1, mrx, oe_ok);
        cs_n[0] = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++;
        if (rx_seen.size() != 0 || miso_oe[0] !== 1'b0 || busy[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: pulses=%0d oe=%b busy=%b, expected 0/0/0",
                     rx_seen.size(), miso_oe[0], busy[0]);
        end
        mtx = '{8'($urandom), 8'h00, 8'h00};
        sb  = '{8'($urandom), 8'h00, 8'h00};
        run_frame(0, 1, mtx, sb, 1, mrx, oe_ok);
        expected = (tx_model.size() != 0) ? tx_model.pop_front() : DEF_TX;
        tests_run++;
        if (mrx[0] !== expected || rx_seen.size() != 1 || rx_seen[0] !== mtx[0]) begin
            tests_failed++;
            $display("[TB] FAIL abort_next_frame: master got %02h exp %02h, slave pulses %0d exp 1 of %02h",
                     mrx[0], expected, rx_seen.size(), mtx[0]);
        end
    endtask

    task automatic test_modes;
        logic [7:0] mtx [3];
        logic [7:0] sb [3];
        logic [7:0] mrx [3];
        logic [7:0] expected;
        bit oe_ok;
        mtx = '{8'h5A, 8'h00, 8'h00};
        sb  = '{8'hA5, 8'h00, 8'h00};
        for (int m = 1; m < 4; m++) begin
            run_frame(m, 1, mtx, sb, 1, mrx, oe_ok);
            expected = (tx_model.size() != 0) ? tx_model.pop_front() : DEF_TX;
            tests_run++;
            if (mrx[0] !== expected || rx_seen.size() != 1 || rx_seen[0] !== mtx[0] || !oe_ok) begin
                tests_failed++;
                $display("[TB] FAIL mode%0d_exchange: master got %02h exp %02h, slave pulses %0d exp 1 of %02h, oe_ok=%b",
                         m, mrx[0], expected, rx_seen.size(), mtx[0], oe_ok);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] mtx [3];
        logic [7:0] sb [3];
        logic [7:0] mrx [3];
        logic [7:0] expected, got;
        bit oe_ok;
        int m, n, offer;
        for (int iter = 0; iter < 8; iter++) begin
            m     = int'($urandom_range(0, 3));
            n     = int'($urandom_range(1, 3));
            offer = int'($urandom_range(0, n));
            for (int k = 0; k < 3; k++) begin
                mtx[k] = 8'($urandom);
                sb[k]  = 8'($urandom);
            end
            run_frame(m, n, mtx, sb, offer, mrx, oe_ok);
            tests_run++;
            if (rx_seen.size() != n || !oe_ok) begin
                tests_failed++;
                $display("[TB] FAIL random%0d_pulses mode %0d: got %0d pulses oe_ok=%b, expected %0d and 1",
                         iter, m, rx_seen.size(), oe_ok, n);
            end
            for (int k = 0; k < n; k++) begin
                expected = (tx_model.size() != 0) ? tx_model.pop_front() : DEF_TX;
                got      = (k < rx_seen.size()) ? rx_seen[k] : 8'hxx;
                tests_run++;
                if (mrx[k] !== expected || got !== mtx[k]) begin
                    tests_failed++;
                    $display("[TB] FAIL random%0d_byte[%0d] mode %0d: master %02h exp %02h, slave %02h exp %02h",
                             iter, k, m, mrx[k], expected, got, mtx[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] mtx [3];
        logic [7:0] sb [3];
        logic [7:0] mrx [3];
        logic [7:0] expected;
        bit oe_ok;
        mtx = '{8'($urandom), 8'h00, 8'h00};
        push_tx(2, 8'($urandom));
        rx_seen.delete();
        spi_xfer(2, 3, mtx, 1'b1, mrx, oe_ok);
        push_tx(2, 8'($urandom));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({tx_ready[2], rx_valid[2], busy[2], miso[2], miso_oe[2]} !== 5'b0 || rx_byte[2] !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: rdy/vld/busy/miso/oe=%b%b%b%b%b byte=%02h, required all 0",
                     tx_ready[2], rx_valid[2], busy[2], miso[2], miso_oe[2], rx_byte[2]);
        end
        cs_n[2] = 1'b1;
        sclk[2] = 1'b1;
        tx_model.delete();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx_ready[2] !== 1'b1 || rx_seen.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_release: ready=%b pulses=%0d, expected 1 and 0", tx_ready[2], rx_seen.size());
        end
        repeat (4) @(negedge clk);
        mtx = '{8'($urandom), 8'h00, 8'h00};
        sb  = '{8'($urandom), 8'h00, 8'h00};
        run_frame(2, 1, mtx, sb, 1, mrx, oe_ok);
        expected = (tx_model.size() != 0) ? tx_model.pop_front() : DEF_TX;
        tests_run++;
        if (mrx[0] !== expected || rx_seen.size() != 1 || rx_seen[0] !== mtx[0]) begin
            tests_failed++;
            $display("[TB] FAIL midreset_next_frame: master got %02h exp %02h, slave pulses %0d exp 1 of %02h",
                     mrx[0], expected, rx_seen.size(), mtx[0]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 4'h0;
        tx_byte  = 8'h00;
        sclk     = 4'b1100;
        cs_n     = 4'hF;
        mosi     = 4'h0;
`ifdef SPI_SLAVE_STATUS_EN
        rx_ack     = 1'b0;
        status_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_burst();
        test_underrun();
        test_abort();
        test_modes();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
